game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Top-level game-flow controller for Frogger. It replaces the two-state IDLE/RUNNING loop in the game top with a full sequencer covering lives, level progression, a timed death freeze, a level-clear pause and game over. It consumes the debounced all-switch start request, the collision flag and the level-up pulse. It drives frog enable, car-motion enable, frog respawn, level and lives to the character, obstacle and display blocks.

Parameters:
C_LIVES, 3, lives loaded at game start (1..3, fits o_Lives).
C_MAX_LEVEL, 15, level saturation value (fits o_Level).
C_FREEZE_CYCLES, 25000000, cycles spent in DYING and in LEVEL_CLEAR (1 s at 25 MHz); must be >= 1.

Ports:
i_Clk  in  1  system clock (25 MHz pixel clock).
i_Rst  in  1  synchronous, active-high reset.
i_Start  in  1  debounced all-switches-pressed level.
i_Has_Collided  in  1  frog/car collision level from the collision block.
i_Level_Up  in  1  one-cycle pulse when the frog reaches the top row.
o_Game_Active  out  1  frog movement enable.
o_Cars_Enable  out  1  obstacle motion enable.
o_Frog_Reset  out  1  one-cycle pulse: frog returns to base position.
o_Level  out  4  current level, 0-based.
o_Lives  out  2  remaining lives.
o_Game_Over  out  1  high while in GAME_OVER.
o_State  out  3  state code, for debug and display.

Behaviour:
- Reset values: state IDLE, o_Level 0, o_Lives C_LIVES, o_Frog_Reset 0, timer 0, start-edge register 1.
- The start-edge register resets to 1 so a switch held through reset does not start a game.
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N, giving 1-cycle latency.
- Start edge: i_Start is 1 now and was 0 on the previous cycle.
- State codes: IDLE=0, RUNNING=1, DYING=2, LEVEL_CLEAR=3, GAME_OVER=4, PAUSED=5.
- IDLE, on start edge: go to RUNNING; load lives=C_LIVES and level=0; pulse o_Frog_Reset.
- RUNNING, on i_Has_Collided: go to DYING; lives decrement by 1, saturating at 0; load timer with C_FREEZE_CYCLES-1.
- RUNNING, on i_Level_Up (no collision): go to LEVEL_CLEAR; level increments, saturating at C_MAX_LEVEL; load timer with C_FREEZE_CYCLES-1.
- RUNNING, collision and level-up in the same cycle: collision wins and the level is unchanged.
- DYING: the timer decrements each cycle. At timer==0:
  - lives==0 (post-decrement): go to GAME_OVER.
  - otherwise: go to RUNNING and pulse o_Frog_Reset.
  - Dwell is exactly C_FREEZE_CYCLES cycles.
- LEVEL_CLEAR: same timer rule; at 0 go to RUNNING and pulse o_Frog_Reset.
- In DYING and LEVEL_CLEAR, i_Has_Collided and i_Level_Up are ignored.
- GAME_OVER, on start edge: same action as the IDLE start.
- o_Game_Active = 1 only in RUNNING.
- o_Cars_Enable = 1 in IDLE, RUNNING and LEVEL_CLEAR; 0 in DYING, GAME_OVER and PAUSED.
- o_Game_Over = 1 only in GAME_OVER.
- o_Frog_Reset is exactly one cycle, asserted in the first cycle in which o_State reads RUNNING after a non-RUNNING state.
- Timer width: $clog2(C_FREEZE_CYCLES+1). It is not reloaded except on the entry transitions above.
- i_Rst mid-freeze or mid-game forces the reset values on the next edge; no respawn pulse is emitted.
- An unused state code recovers to IDLE on the next edge.

Optional Feature:
GAME_SEQ_PAUSE_EN:
- When defined, adds input port i_Pause (1 bit, debounced level).
- A rising edge of i_Pause in RUNNING goes to PAUSED. In PAUSED, the timer, lives and level are frozen and collisions are ignored.
- A rising edge of i_Pause in PAUSED returns to RUNNING with no frog reset.
- The i_Pause edge register resets to 1.
- When not defined: no port, PAUSED is unreachable, and code 5 is treated as an unused code.

Test Plan:
- Use C_LIVES=2, C_FREEZE_CYCLES=4 throughout.
- Reset with i_Start held high, then keep it high for 10 cycles -> state stays IDLE (0); o_Cars_Enable=1; o_Game_Active=0.
- From IDLE, drive i_Start 0->1 -> next cycle o_State=1, o_Frog_Reset=1 for one cycle, o_Lives=2, o_Level=0.
- In RUNNING, pulse i_Has_Collided -> o_State=2 and o_Lives=1 for exactly 4 cycles, o_Cars_Enable=0; then o_State=1 with o_Frog_Reset=1.
- Second collision -> DYING for 4 cycles, o_Lives=0 -> GAME_OVER (o_Game_Over=1); then a start edge -> RUNNING, lives=2, level=0.
- Assert i_Level_Up and i_Has_Collided in the same cycle -> DYING, o_Level unchanged.
- Issue 16 clean level-ups -> o_Level saturates at 15.
- Assert i_Rst at timer==2 in DYING -> next cycle IDLE, lives=2, level=0, no o_Frog_Reset.

Source files
------------

// File: rtl/game_sequencer.sv
// Frogger game-flow sequencer: lives, level progression, death freeze, level-clear pause, game over.
// Latency: 1 cycle; every output is registered and reflects the inputs sampled at the previous edge.
// Backpressure: none; inputs are levels/pulses consumed every cycle, with no stall path.
//
// Optional feature macro: GAME_SEQ_PAUSE_EN (adds i_Pause and the PAUSED state).
//
// Ports:
//   i_Clk, i_Rst     25 MHz clock, synchronous active-high reset
//   i_Start          debounced all-switches level; its rising edge starts a game
//   i_Has_Collided   frog/car collision level
//   i_Level_Up       one-cycle pulse when the frog reaches the top row
//   i_Pause          (GAME_SEQ_PAUSE_EN only) debounced pause level; rising edge toggles pause
//   o_Game_Active    frog movement enable (RUNNING only)
//   o_Cars_Enable    obstacle motion enable (IDLE, RUNNING, LEVEL_CLEAR)
//   o_Frog_Reset     one-cycle respawn pulse on entry to RUNNING from a freeze/start
//   o_Level          current level, 0-based, saturating
//   o_Lives          remaining lives
//   o_Game_Over      high while in GAME_OVER
//   o_State          state code for debug/display
module game_sequencer #(
  parameter int unsigned C_LIVES         = 3,
  parameter int unsigned C_MAX_LEVEL     = 15,
  parameter int unsigned C_FREEZE_CYCLES = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Has_Collided,
  input  logic       i_Level_Up,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic       i_Pause,
`endif
  output logic       o_Game_Active,
  output logic       o_Cars_Enable,
  output logic       o_Frog_Reset,
  output logic [3:0] o_Level,
  output logic [1:0] o_Lives,
  output logic       o_Game_Over,
  output logic [2:0] o_State
);

  localparam int unsigned TW = $clog2(C_FREEZE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(C_FREEZE_CYCLES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(C_LIVES);
  localparam logic [3:0]    LEVEL_MAX  = 4'(C_MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_RUNNING     = 3'd1,
    S_DYING       = 3'd2,
    S_LEVEL_CLEAR = 3'd3,
    S_GAME_OVER   = 3'd4,
    S_PAUSED      = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      lives_q, lives_d;
  logic [3:0]      level_q, level_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            frog_reset_q, frog_reset_d;
  logic            start_prev_q;
  logic            game_active_q, cars_enable_q, game_over_q;
  logic            start_edge;

`ifdef GAME_SEQ_PAUSE_EN
  logic            pause_prev_q;
  logic            pause_edge;
  assign pause_edge = i_Pause & ~pause_prev_q;
`endif

  assign start_edge = i_Start & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    timer_d      = timer_q;
    frog_reset_d = 1'b0;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_edge) begin
          state_d      = S_RUNNING;
          lives_d      = LIVES_INIT;
          level_d      = 4'd0;
          frog_reset_d = 1'b1;
        end
      end

      S_RUNNING: begin
        // Collision has priority over a simultaneous level-up.
        if (i_Has_Collided) begin
          state_d = S_DYING;
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          timer_d = TIMER_LOAD;
        end else if (i_Level_Up) begin
          state_d = S_LEVEL_CLEAR;
          level_d = (level_q < LEVEL_MAX) ? level_q + 4'd1 : LEVEL_MAX;
          timer_d = TIMER_LOAD;
`ifdef GAME_SEQ_PAUSE_EN
        end else if (pause_edge) begin
          state_d = S_PAUSED;
`endif
        end
      end

      // Timer loaded with N-1 on entry and exits on the edge where it reads 0,
      // giving exactly N cycles of dwell.
      S_DYING: begin
        if (timer_q == '0) begin
          if (lives_q == 2'd0) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d      = S_RUNNING;
            frog_reset_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_LEVEL_CLEAR: begin
        if (timer_q == '0) begin
          state_d      = S_RUNNING;
          frog_reset_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

`ifdef GAME_SEQ_PAUSE_EN
      // Everything frozen; resume without a respawn.
      S_PAUSED: begin
        if (pause_edge) begin
          state_d = S_RUNNING;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q       <= S_IDLE;
      lives_q       <= LIVES_INIT;
      level_q       <= 4'd0;
      timer_q       <= '0;
      frog_reset_q  <= 1'b0;
      // Reset high so a switch held through reset is not seen as a new press.
      start_prev_q  <= 1'b1;
      game_active_q <= 1'b0;
      cars_enable_q <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      timer_q       <= timer_d;
      frog_reset_q  <= frog_reset_d;
      start_prev_q  <= i_Start;
      game_active_q <= (state_d == S_RUNNING);
      cars_enable_q <= (state_d == S_IDLE) || (state_d == S_RUNNING) ||
                       (state_d == S_LEVEL_CLEAR);
      game_over_q   <= (state_d == S_GAME_OVER);
    end
  end

`ifdef GAME_SEQ_PAUSE_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pause_prev_q <= 1'b1;
    end else begin
      pause_prev_q <= i_Pause;
    end
  end
`endif

  assign o_Game_Active = game_active_q;
  assign o_Cars_Enable = cars_enable_q;
  assign o_Frog_Reset  = frog_reset_q;
  assign o_Level       = level_q;
  assign o_Lives       = lives_q;
  assign o_Game_Over   = game_over_q;
  assign o_State       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenario followed by random play,
// every cycle compared against a rule-level model of the game flow.
module tb_game_sequencer;

  localparam int LIVES  = 2;
  localparam int FREEZE = 4;
  localparam int MAXL   = 15;

  logic       clk = 1'b0;
  logic       rst, start, coll, lu;
  logic       ga, ce, fr, go;
  logic [3:0] lvl;
  logic [1:0] lives;
  logic [2:0] st;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: state by name-code, lives, level, cycles of freeze remaining.
  int m_state, m_lives, m_level, m_left;
  bit m_prev_start, m_frog;

  always #5 clk = ~clk;

  game_sequencer #(
    .C_LIVES        (LIVES),
    .C_MAX_LEVEL    (MAXL),
    .C_FREEZE_CYCLES(FREEZE)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Start       (start),
    .i_Has_Collided(coll),
    .i_Level_Up    (lu),
    .o_Game_Active (ga),
    .o_Cars_Enable (ce),
    .o_Frog_Reset  (fr),
    .o_Level       (lvl),
    .o_Lives       (lives),
    .o_Game_Over   (go),
    .o_State       (st)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the game rules, compare.
  task automatic step(input bit r, input bit s, input bit c, input bit l);
    bit se;
    rst = r; start = s; coll = c; lu = l;
    @(posedge clk);
    #1;
    se     = s && !m_prev_start;
    m_frog = 0;
    if (r) begin
      m_state = 0; m_lives = LIVES; m_level = 0; m_left = 0; m_prev_start = 1;
    end else begin
      m_prev_start = s;
      if (m_state == 0 || m_state == 4) begin
        if (se) begin
          m_state = 1; m_lives = LIVES; m_level = 0; m_frog = 1;
        end
      end else if (m_state == 1) begin
        if (c) begin
          m_state = 2; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_left = FREEZE;
        end else if (l) begin
          m_state = 3; m_level = (m_level < MAXL) ? m_level + 1 : MAXL; m_left = FREEZE;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_state == 2 && m_lives == 0) m_state = 4;
          else begin m_state = 1; m_frog = 1; end
        end
      end
    end
    check("state",       8'(st),    8'(m_state));
    check("lives",       8'(lives), 8'(m_lives));
    check("level",       8'(lvl),   8'(m_level));
    check("frog_reset",  8'(fr),    8'(m_frog));
    check("game_active", 8'(ga),    8'(m_state == 1));
    check("cars_enable", 8'(ce),    8'(m_state == 0 || m_state == 1 || m_state == 3));
    check("game_over",   8'(go),    8'(m_state == 4));
  endtask

  initial begin
    bit s;
    rst = 1'b1; start = 1'b1; coll = 1'b0; lu = 1'b0;
    m_state = 0; m_lives = LIVES; m_level = 0; m_left = 0; m_prev_start = 1; m_frog = 0;

    // Reset with start held, then keep holding: must stay IDLE.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    check("held_start_idle", 8'(st), 8'd0);

    // Start edge.
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("start_frog_pulse", 8'(fr), 8'd1);
    step(0, 1, 0, 0);

    // First collision: 4 cycles DYING then respawn.
    step(0, 1, 1, 0);
    for (int i = 0; i < FREEZE; i++) step(0, 1, 0, 0);
    check("respawn_pulse", 8'(fr), 8'd1);
    step(0, 1, 0, 0);

    // Second collision -> GAME_OVER, then restart.
    step(0, 1, 1, 0);
    for (int i = 0; i < FREEZE + 2; i++) step(0, 1, 0, 0);
    check("game_over_flag", 8'(go), 8'd1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("restart_lives", 8'(lives), 8'd2);

    // Collision and level-up together: collision wins, level unchanged.
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    check("coll_wins_level", 8'(lvl), 8'd0);
    for (int i = 0; i < FREEZE + 1; i++) step(0, 1, 0, 0);

    // 16 clean level-ups saturate at 15.
    for (int n = 0; n < 16; n++) begin
      step(0, 1, 0, 1);
      for (int i = 0; i < FREEZE; i++) step(0, 1, 0, 0);
    end
    check("level_saturates", 8'(lvl), 8'd15);

    // Reset mid-freeze with timer at 2.
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("rst_idle",  8'(st),    8'd0);
    check("rst_lives", 8'(lives), 8'd2);
    check("rst_level", 8'(lvl),   8'd0);
    check("rst_no_fr", 8'(fr),    8'd0);

    // Random play.
    s = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) s = ~s;
      step($urandom_range(0, 79) == 0, s,
           $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
